c1_sb_xbar_2m2s: RTL and testbench
==================================

# c1_sb_xbar_2m2s

Two-master, two-slave system-bus crossbar between the core BIU (master 0 = instruction fetch, master 1 = load/store) and the on-chip slaves (slave 0 = main RAM, slave 1 = peripheral region). It decodes each request address to a slave and arbitrates per slave with fixed priority, master 1 over master 0. It records which master owns each slave's outstanding read and write, and routes the read-data and write-response beats back to that owner. Arbitration and routing add no register stage.

## Interface
Parameters:
- S1_BASE, 32'h1000_0000, slave 1 region base.
- S1_MASK, 32'hF000_0000, region match mask. An address hits slave 1 when (addr & S1_MASK) == S1_BASE; every other address goes to slave 0.

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- sb_arvalid_m{0,1} / sb_arready_m{0,1} / sb_araddr_m{0,1}  in/out/in  1/1/32  master read-address channel.
- sb_rvalid_m{0,1} / sb_rready_m{0,1} / sb_rdata_m{0,1}  out/in/out  1/1/32  master read-data channel.
- sb_wvalid_m{0,1} / sb_wready_m{0,1} / sb_waddr_m{0,1} / sb_wdata_m{0,1} / sb_wstrb_m{0,1}  in/out/in/in/in  1/1/32/32/4  master write channel (address, data and strobe travel in one beat).
- sb_bvalid_m{0,1} / sb_bready_m{0,1} / sb_bresp_m{0,1}  out/in/out  1/1/1  master write response.
- sb_arvalid_s{0,1} / sb_arready_s{0,1} / sb_araddr_s{0,1}  out/in/out  1/1/32  slave read-address channel.
- sb_rvalid_s{0,1} / sb_rready_s{0,1} / sb_rdata_s{0,1}  in/out/in  1/1/32  slave read-data channel.
- sb_wvalid_s{0,1} / sb_wready_s{0,1} / sb_waddr_s{0,1} / sb_wdata_s{0,1} / sb_wstrb_s{0,1}  out/in/out/out/out  1/1/32/32/4  slave write channel.
- sb_bvalid_s{0,1} / sb_bready_s{0,1} / sb_bresp_s{0,1}  in/out/in  1/1/1  slave write response.

## Operation
Master contract:
- Each master has at most one outstanding read and one outstanding write.
- A master holds valid and its payload stable until ready.

Slave contract:
- A slave returns rvalid or bvalid at least 1 cycle after the address handshake.
- Each slave accepts at most one outstanding read and one outstanding write.

Per slave, per channel (read and write are independent and identical):
- Request to slave s = master valid & decode hit s.
- Free = no owner recorded, or the owner's response handshakes in this cycle (back-to-back issue allowed).
- Grant: m1 if it requests s, else m0. Only when free.
- Grant is combinational on the current-cycle request; there is no grant register, so the winner may change between cycles while a loser waits.
- Slave valid = free & any request to s. Slave payload is muxed from the granted master.
- Master ready = granted & free & slave ready.
- On the address or write handshake, the owner register is loaded with {valid=1, id=granted master}.
- Owner states: IDLE, BUSY_M0, BUSY_M1.
  - IDLE -> BUSY_mX on handshake.
  - BUSY -> IDLE on a response handshake with no new handshake in the same cycle.
  - BUSY -> BUSY_mY on response plus a new handshake in the same cycle.

Response routing:
- rvalid/rdata_s go to the owner master. The non-owner sees rvalid=0 and rdata=0.
- rready_s = rready of the owner master; it is 1 when the slave has no owner.
- bvalid, bresp and bready are routed the same way.

Boundary cases:
- Both masters target different slaves in the same cycle: both are granted in that cycle.
- Both target the same slave: m1 wins, m0 sees ready=0 and holds its request.
- A response arriving from a slave with no owner (stale after reset) is acknowledged (ready=1) and dropped; no master sees valid.

## Timing
- Zero-cycle request and response paths: valid to slave valid and slave rvalid to master rvalid are combinational.
- Owner registers update on the clk edge of the handshake.
- Reset values:
  - All owners IDLE.
  - All master-side valid/ready outputs 0 except rready_s/bready_s = 1.
  - All data outputs 0 while no request is present.
- Reset asserted mid-transaction clears owners immediately. A response that arrives afterwards is dropped per the rule above.
- Back-to-back throughput: one read and one write per slave per cycle, once a response and a new request coincide.

## Structure
- Shared package c1_sb_pkg holds:
  - master id localparams: M_IFU=0, M_LSU=1
  - owner state encodings IDLE/BUSY_M0/BUSY_M1
  - default S1_BASE/S1_MASK
- One natural sub-module: c1_sb_slave_port. It holds the arbiter, owner register and response demux for one slave's read plus write channels, and is instantiated twice.
- The top level contains only address decode and the OR-combination of per-slave responses and readies per master.

## Test plan
- m0 read 0x0000_0100, slave 0 arready=1, rvalid 2 cycles later with 0xDEADBEEF -> m0 arready=1 in cycle 0, m0 rvalid=1 / rdata=0xDEADBEEF in cycle 2, m1 rvalid=0.
- m0 and m1 read 0x0000_0040 in the same cycle -> m1 granted, m0 arready=0. m0 is granted in the cycle m1's rvalid returns (back-to-back).
- m0 read 0x0000_0000 and m1 write 0x1000_0004, data 0x55, strb 4'h1, simultaneously -> both handshake in cycle 0 on s0 and s1 respectively. bvalid and bresp=0 reach m1 only.
- Slave 1 arready=0 for 3 cycles with m1 read 0x1000_0008 pending -> sb_arvalid_s1 held high with araddr stable. m1 arready rises in the cycle slave arready=1.
- Issue m1 read to slave 0, assert rst_n low before rvalid, release, then slave 0 pulses rvalid=1 -> no master sees rvalid, rready_s0=1, owner stays IDLE.
- m1 writes 0x0000_0010 twice back-to-back with slave bvalid in cycle 1 -> second write handshakes in cycle 1. The owner stays BUSY_M1 and the second bvalid routes to m1.

Source files
------------

// File: rtl/c1_sb_pkg.sv
// rtl/c1_sb_pkg.sv - shared types and constants for the c1 system-bus crossbar
// Contents: master ids, per-channel owner state encoding, default slave 1 region,
// and small helpers for address decode and owner encoding.
package c1_sb_pkg;

  localparam logic M_IFU = 1'b0;
  localparam logic M_LSU = 1'b1;

  localparam logic [31:0] S1_BASE_DEF = 32'h1000_0000;
  localparam logic [31:0] S1_MASK_DEF = 32'hF000_0000;

  typedef enum logic [1:0] {
    OWN_IDLE    = 2'd0,
    OWN_BUSY_M0 = 2'd1,
    OWN_BUSY_M1 = 2'd2
  } own_state_t;

  function automatic logic hit_s1(input logic [31:0] addr,
                                  input logic [31:0] base,
                                  input logic [31:0] mask);
    return (addr & mask) == base;
  endfunction

  function automatic own_state_t own_busy(input logic id);
    return (id == M_LSU) ? OWN_BUSY_M1 : OWN_BUSY_M0;
  endfunction

endpackage

// File: rtl/c1_sb_xbar_2m2s_slave_port.sv
// rtl/c1_sb_xbar_2m2s_slave_port.sv - arbiter, owner tracking and response demux for one slave
// Ports:
//   clk, rst_n                 clock, async active-low reset
//   ar_req_m*/araddr_m*        decoded read requests from each master, arready_m* back
//   rvalid_m*/rdata_m*         read data routed to the owning master, rready_m* in
//   w_req_m*/waddr_m*/...      decoded write requests from each master, wready_m* back
//   bvalid_m*/bresp_m*         write response routed to the owning master, bready_m* in
//   *_s                        the slave's own read/write/response channels
module c1_sb_slave_port
  import c1_sb_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  // read address from masters (already decoded to this slave)
  input  logic        ar_req_m0,
  input  logic        ar_req_m1,
  input  logic [31:0] araddr_m0,
  input  logic [31:0] araddr_m1,
  output logic        arready_m0,
  output logic        arready_m1,
  // read data to masters
  output logic        rvalid_m0,
  output logic        rvalid_m1,
  output logic [31:0] rdata_m0,
  output logic [31:0] rdata_m1,
  input  logic        rready_m0,
  input  logic        rready_m1,
  // write from masters (already decoded to this slave)
  input  logic        w_req_m0,
  input  logic        w_req_m1,
  input  logic [31:0] waddr_m0,
  input  logic [31:0] waddr_m1,
  input  logic [31:0] wdata_m0,
  input  logic [31:0] wdata_m1,
  input  logic [3:0]  wstrb_m0,
  input  logic [3:0]  wstrb_m1,
  output logic        wready_m0,
  output logic        wready_m1,
  // write response to masters
  output logic        bvalid_m0,
  output logic        bvalid_m1,
  output logic        bresp_m0,
  output logic        bresp_m1,
  input  logic        bready_m0,
  input  logic        bready_m1,
  // slave side
  output logic        arvalid_s,
  input  logic        arready_s,
  output logic [31:0] araddr_s,
  input  logic        rvalid_s,
  output logic        rready_s,
  input  logic [31:0] rdata_s,
  output logic        wvalid_s,
  input  logic        wready_s,
  output logic [31:0] waddr_s,
  output logic [31:0] wdata_s,
  output logic [3:0]  wstrb_s,
  input  logic        bvalid_s,
  output logic        bready_s,
  input  logic        bresp_s
);

  own_state_t rd_own;
  own_state_t wr_own;

  logic rd_free;
  logic wr_free;
  logic ar_hs;
  logic w_hs;
  logic r_hs;
  logic b_hs;

  // ---------------- read channel ----------------

  // With no owner the slave's ready is held high so a stale beat is drained.
  always_comb begin
    rready_s = 1'b1;
    case (rd_own)
      OWN_BUSY_M0: rready_s = rready_m0;
      OWN_BUSY_M1: rready_s = rready_m1;
      default:     rready_s = 1'b1;
    endcase
  end

  // A response retiring this cycle frees the slave for a same-cycle reissue.
  assign rd_free   = (rd_own == OWN_IDLE) || (rvalid_s && rready_s);
  assign arvalid_s = rd_free && (ar_req_m0 || ar_req_m1);
  // Payload follows the fixed-priority winner; zero when nobody requests.
  assign araddr_s  = ar_req_m1 ? araddr_m1 : (ar_req_m0 ? araddr_m0 : 32'd0);

  assign arready_m1 = ar_req_m1 && rd_free && arready_s;
  assign arready_m0 = ar_req_m0 && !ar_req_m1 && rd_free && arready_s;

  assign ar_hs = arvalid_s && arready_s;
  assign r_hs  = rvalid_s && rready_s && (rd_own != OWN_IDLE);

  assign rvalid_m0 = rvalid_s && (rd_own == OWN_BUSY_M0);
  assign rvalid_m1 = rvalid_s && (rd_own == OWN_BUSY_M1);
  assign rdata_m0  = rvalid_m0 ? rdata_s : 32'd0;
  assign rdata_m1  = rvalid_m1 ? rdata_s : 32'd0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_own <= OWN_IDLE;
    end else if (ar_hs) begin
      rd_own <= own_busy(ar_req_m1 ? M_LSU : M_IFU);
    end else if (r_hs) begin
      rd_own <= OWN_IDLE;
    end
  end

  // ---------------- write channel ----------------

  always_comb begin
    bready_s = 1'b1;
    case (wr_own)
      OWN_BUSY_M0: bready_s = bready_m0;
      OWN_BUSY_M1: bready_s = bready_m1;
      default:     bready_s = 1'b1;
    endcase
  end

  assign wr_free  = (wr_own == OWN_IDLE) || (bvalid_s && bready_s);
  assign wvalid_s = wr_free && (w_req_m0 || w_req_m1);
  assign waddr_s  = w_req_m1 ? waddr_m1 : (w_req_m0 ? waddr_m0 : 32'd0);
  assign wdata_s  = w_req_m1 ? wdata_m1 : (w_req_m0 ? wdata_m0 : 32'd0);
  assign wstrb_s  = w_req_m1 ? wstrb_m1 : (w_req_m0 ? wstrb_m0 : 4'd0);

  assign wready_m1 = w_req_m1 && wr_free && wready_s;
  assign wready_m0 = w_req_m0 && !w_req_m1 && wr_free && wready_s;

  assign w_hs = wvalid_s && wready_s;
  assign b_hs = bvalid_s && bready_s && (wr_own != OWN_IDLE);

  assign bvalid_m0 = bvalid_s && (wr_own == OWN_BUSY_M0);
  assign bvalid_m1 = bvalid_s && (wr_own == OWN_BUSY_M1);
  assign bresp_m0  = bvalid_m0 && bresp_s;
  assign bresp_m1  = bvalid_m1 && bresp_s;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_own <= OWN_IDLE;
    end else if (w_hs) begin
      wr_own <= own_busy(w_req_m1 ? M_LSU : M_IFU);
    end else if (b_hs) begin
      wr_own <= OWN_IDLE;
    end
  end

endmodule

// File: rtl/c1_sb_xbar_2m2s.sv
// rtl/c1_sb_xbar_2m2s.sv - two-master two-slave system-bus crossbar, no register stage
// Ports:
//   clk, rst_n       clock, async active-low reset
//   sb_*_m0          master 0 (instruction fetch) read, read-data, write, write-response
//   sb_*_m1          master 1 (load/store), same channels
//   sb_*_s0          slave 0 (main RAM), mirrored channels
//   sb_*_s1          slave 1 (peripheral region selected by S1_BASE/S1_MASK)
module c1_sb_xbar_2m2s
  import c1_sb_pkg::*;
#(
  parameter logic [31:0] S1_BASE = S1_BASE_DEF,
  parameter logic [31:0] S1_MASK = S1_MASK_DEF
) (
  input  logic        clk,
  input  logic        rst_n,
  // master 0
  input  logic        sb_arvalid_m0,
  output logic        sb_arready_m0,
  input  logic [31:0] sb_araddr_m0,
  output logic        sb_rvalid_m0,
  input  logic        sb_rready_m0,
  output logic [31:0] sb_rdata_m0,
  input  logic        sb_wvalid_m0,
  output logic        sb_wready_m0,
  input  logic [31:0] sb_waddr_m0,
  input  logic [31:0] sb_wdata_m0,
  input  logic [3:0]  sb_wstrb_m0,
  output logic        sb_bvalid_m0,
  input  logic        sb_bready_m0,
  output logic        sb_bresp_m0,
  // master 1
  input  logic        sb_arvalid_m1,
  output logic        sb_arready_m1,
  input  logic [31:0] sb_araddr_m1,
  output logic        sb_rvalid_m1,
  input  logic        sb_rready_m1,
  output logic [31:0] sb_rdata_m1,
  input  logic        sb_wvalid_m1,
  output logic        sb_wready_m1,
  input  logic [31:0] sb_waddr_m1,
  input  logic [31:0] sb_wdata_m1,
  input  logic [3:0]  sb_wstrb_m1,
  output logic        sb_bvalid_m1,
  input  logic        sb_bready_m1,
  output logic        sb_bresp_m1,
  // slave 0
  output logic        sb_arvalid_s0,
  input  logic        sb_arready_s0,
  output logic [31:0] sb_araddr_s0,
  input  logic        sb_rvalid_s0,
  output logic        sb_rready_s0,
  input  logic [31:0] sb_rdata_s0,
  output logic        sb_wvalid_s0,
  input  logic        sb_wready_s0,
  output logic [31:0] sb_waddr_s0,
  output logic [31:0] sb_wdata_s0,
  output logic [3:0]  sb_wstrb_s0,
  input  logic        sb_bvalid_s0,
  output logic        sb_bready_s0,
  input  logic        sb_bresp_s0,
  // slave 1
  output logic        sb_arvalid_s1,
  input  logic        sb_arready_s1,
  output logic [31:0] sb_araddr_s1,
  input  logic        sb_rvalid_s1,
  output logic        sb_rready_s1,
  input  logic [31:0] sb_rdata_s1,
  output logic        sb_wvalid_s1,
  input  logic        sb_wready_s1,
  output logic [31:0] sb_waddr_s1,
  output logic [31:0] sb_wdata_s1,
  output logic [3:0]  sb_wstrb_s1,
  input  logic        sb_bvalid_s1,
  output logic        sb_bready_s1,
  input  logic        sb_bresp_s1
);

  // Address decode: slave 1 on region match, slave 0 otherwise.
  logic ar_hit1_m0, ar_hit1_m1, w_hit1_m0, w_hit1_m1;

  assign ar_hit1_m0 = hit_s1(sb_araddr_m0, S1_BASE, S1_MASK);
  assign ar_hit1_m1 = hit_s1(sb_araddr_m1, S1_BASE, S1_MASK);
  assign w_hit1_m0  = hit_s1(sb_waddr_m0,  S1_BASE, S1_MASK);
  assign w_hit1_m1  = hit_s1(sb_waddr_m1,  S1_BASE, S1_MASK);

  // Per-slave-port master-facing results, OR-combined below.
  logic        s0_arready_m0, s0_arready_m1, s1_arready_m0, s1_arready_m1;
  logic        s0_rvalid_m0,  s0_rvalid_m1,  s1_rvalid_m0,  s1_rvalid_m1;
  logic [31:0] s0_rdata_m0,   s0_rdata_m1,   s1_rdata_m0,   s1_rdata_m1;
  logic        s0_wready_m0,  s0_wready_m1,  s1_wready_m0,  s1_wready_m1;
  logic        s0_bvalid_m0,  s0_bvalid_m1,  s1_bvalid_m0,  s1_bvalid_m1;
  logic        s0_bresp_m0,   s0_bresp_m1,   s1_bresp_m0,   s1_bresp_m1;

  c1_sb_slave_port u_s0 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ar_req_m0  (sb_arvalid_m0 && !ar_hit1_m0),
    .ar_req_m1  (sb_arvalid_m1 && !ar_hit1_m1),
    .araddr_m0  (sb_araddr_m0),
    .araddr_m1  (sb_araddr_m1),
    .arready_m0 (s0_arready_m0),
    .arready_m1 (s0_arready_m1),
    .rvalid_m0  (s0_rvalid_m0),
    .rvalid_m1  (s0_rvalid_m1),
    .rdata_m0   (s0_rdata_m0),
    .rdata_m1   (s0_rdata_m1),
    .rready_m0  (sb_rready_m0),
    .rready_m1  (sb_rready_m1),
    .w_req_m0   (sb_wvalid_m0 && !w_hit1_m0),
    .w_req_m1   (sb_wvalid_m1 && !w_hit1_m1),
    .waddr_m0   (sb_waddr_m0),
    .waddr_m1   (sb_waddr_m1),
    .wdata_m0   (sb_wdata_m0),
    .wdata_m1   (sb_wdata_m1),
    .wstrb_m0   (sb_wstrb_m0),
    .wstrb_m1   (sb_wstrb_m1),
    .wready_m0  (s0_wready_m0),
    .wready_m1  (s0_wready_m1),
    .bvalid_m0  (s0_bvalid_m0),
    .bvalid_m1  (s0_bvalid_m1),
    .bresp_m0   (s0_bresp_m0),
    .bresp_m1   (s0_bresp_m1),
    .bready_m0  (sb_bready_m0),
    .bready_m1  (sb_bready_m1),
    .arvalid_s  (sb_arvalid_s0),
    .arready_s  (sb_arready_s0),
    .araddr_s   (sb_araddr_s0),
    .rvalid_s   (sb_rvalid_s0),
    .rready_s   (sb_rready_s0),
    .rdata_s    (sb_rdata_s0),
    .wvalid_s   (sb_wvalid_s0),
    .wready_s   (sb_wready_s0),
    .waddr_s    (sb_waddr_s0),
    .wdata_s    (sb_wdata_s0),
    .wstrb_s    (sb_wstrb_s0),
    .bvalid_s   (sb_bvalid_s0),
    .bready_s   (sb_bready_s0),
    .bresp_s    (sb_bresp_s0)
  );

  c1_sb_slave_port u_s1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .ar_req_m0  (sb_arvalid_m0 && ar_hit1_m0),
    .ar_req_m1  (sb_arvalid_m1 && ar_hit1_m1),
    .araddr_m0  (sb_araddr_m0),
    .araddr_m1  (sb_araddr_m1),
    .arready_m0 (s1_arready_m0),
    .arready_m1 (s1_arready_m1),
    .rvalid_m0  (s1_rvalid_m0),
    .rvalid_m1  (s1_rvalid_m1),
    .rdata_m0   (s1_rdata_m0),
    .rdata_m1   (s1_rdata_m1),
    .rready_m0  (sb_rready_m0),
    .rready_m1  (sb_rready_m1),
    .w_req_m0   (sb_wvalid_m0 && w_hit1_m0),
    .w_req_m1   (sb_wvalid_m1 && w_hit1_m1),
    .waddr_m0   (sb_waddr_m0),
    .waddr_m1   (sb_waddr_m1),
    .wdata_m0   (sb_wdata_m0),
    .wdata_m1   (sb_wdata_m1),
    .wstrb_m0   (sb_wstrb_m0),
    .wstrb_m1   (sb_wstrb_m1),
    .wready_m0  (s1_wready_m0),
    .wready_m1  (s1_wready_m1),
    .bvalid_m0  (s1_bvalid_m0),
    .bvalid_m1  (s1_bvalid_m1),
    .bresp_m0   (s1_bresp_m0),
    .bresp_m1   (s1_bresp_m1),
    .bready_m0  (sb_bready_m0),
    .bready_m1  (sb_bready_m1),
    .arvalid_s  (sb_arvalid_s1),
    .arready_s  (sb_arready_s1),
    .araddr_s   (sb_araddr_s1),
    .rvalid_s   (sb_rvalid_s1),
    .rready_s   (sb_rready_s1),
    .rdata_s    (sb_rdata_s1),
    .wvalid_s   (sb_wvalid_s1),
    .wready_s   (sb_wready_s1),
    .waddr_s    (sb_waddr_s1),
    .wdata_s    (sb_wdata_s1),
    .wstrb_s    (sb_wstrb_s1),
    .bvalid_s   (sb_bvalid_s1),
    .bready_s   (sb_bready_s1),
    .bresp_s    (sb_bresp_s1)
  );

  // Each master has at most one read and one write in flight, so at most one
  // slave port drives a non-zero value toward it and a plain OR suffices.
  assign sb_arready_m0 = s0_arready_m0 | s1_arready_m0;
  assign sb_arready_m1 = s0_arready_m1 | s1_arready_m1;
  assign sb_rvalid_m0  = s0_rvalid_m0  | s1_rvalid_m0;
  assign sb_rvalid_m1  = s0_rvalid_m1  | s1_rvalid_m1;
  assign sb_rdata_m0   = s0_rdata_m0   | s1_rdata_m0;
  assign sb_rdata_m1   = s0_rdata_m1   | s1_rdata_m1;
  assign sb_wready_m0  = s0_wready_m0  | s1_wready_m0;
  assign sb_wready_m1  = s0_wready_m1  | s1_wready_m1;
  assign sb_bvalid_m0  = s0_bvalid_m0  | s1_bvalid_m0;
  assign sb_bvalid_m1  = s0_bvalid_m1  | s1_bvalid_m1;
  assign sb_bresp_m0   = s0_bresp_m0   | s1_bresp_m0;
  assign sb_bresp_m1   = s0_bresp_m1   | s1_bresp_m1;

endmodule

// File: tb/tb_c1_sb_xbar_2m2s.sv
// tb/tb_c1_sb_xbar_2m2s.sv - table-driven bench for the two-master two-slave crossbar
module tb_c1_sb_xbar_2m2s;

  typedef struct {
    logic             rst_n;
    logic [1:0]       arvalid, rready, wvalid, bready;
    logic [1:0][31:0] araddr, waddr, wdata;
    logic [1:0][3:0]  wstrb;
    logic [1:0]       arready_s, rvalid_s, wready_s, bvalid_s, bresp_s;
    logic [1:0][31:0] rdata_s;
    logic [1:0]       e_arready, e_rvalid, e_wready, e_bvalid, e_bresp;
    logic [1:0]       e_arvalid_s, e_rready_s, e_wvalid_s, e_bready_s;
    logic [1:0][31:0] e_rdata, e_araddr_s, e_waddr_s, e_wdata_s;
    logic [1:0][3:0]  e_wstrb_s;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [1:0]       arvalid_m, rready_m, wvalid_m, bready_m;
  logic [1:0][31:0] araddr_m, waddr_m, wdata_m;
  logic [1:0][3:0]  wstrb_m;
  logic [1:0]       arready_s, rvalid_s, wready_s, bvalid_s, bresp_s;
  logic [1:0][31:0] rdata_s;

  wire [1:0]        arready_m, rvalid_m, wready_m, bvalid_m, bresp_m;
  wire [1:0][31:0]  rdata_m;
  wire [1:0]        arvalid_s, rready_s, wvalid_s, bready_s;
  wire [1:0][31:0]  araddr_s, waddr_s, wdata_s;
  wire [1:0][3:0]   wstrb_s;

  int n_vec = 0;
  int n_cmp = 0;
  int miscompares = 0;

  c1_sb_xbar_2m2s dut (
    .clk(clk), .rst_n(rst_n),
    .sb_arvalid_m0(arvalid_m[0]), .sb_arready_m0(arready_m[0]), .sb_araddr_m0(araddr_m[0]),
    .sb_rvalid_m0(rvalid_m[0]), .sb_rready_m0(rready_m[0]), .sb_rdata_m0(rdata_m[0]),
    .sb_wvalid_m0(wvalid_m[0]), .sb_wready_m0(wready_m[0]), .sb_waddr_m0(waddr_m[0]),
    .sb_wdata_m0(wdata_m[0]), .sb_wstrb_m0(wstrb_m[0]),
    .sb_bvalid_m0(bvalid_m[0]), .sb_bready_m0(bready_m[0]), .sb_bresp_m0(bresp_m[0]),
    .sb_arvalid_m1(arvalid_m[1]), .sb_arready_m1(arready_m[1]), .sb_araddr_m1(araddr_m[1]),
    .sb_rvalid_m1(rvalid_m[1]), .sb_rready_m1(rready_m[1]), .sb_rdata_m1(rdata_m[1]),
    .sb_wvalid_m1(wvalid_m[1]), .sb_wready_m1(wready_m[1]), .sb_waddr_m1(waddr_m[1]),
    .sb_wdata_m1(wdata_m[1]), .sb_wstrb_m1(wstrb_m[1]),
    .sb_bvalid_m1(bvalid_m[1]), .sb_bready_m1(bready_m[1]), .sb_bresp_m1(bresp_m[1]),
    .sb_arvalid_s0(arvalid_s[0]), .sb_arready_s0(arready_s[0]), .sb_araddr_s0(araddr_s[0]),
    .sb_rvalid_s0(rvalid_s[0]), .sb_rready_s0(rready_s[0]), .sb_rdata_s0(rdata_s[0]),
    .sb_wvalid_s0(wvalid_s[0]), .sb_wready_s0(wready_s[0]), .sb_waddr_s0(waddr_s[0]),
    .sb_wdata_s0(wdata_s[0]), .sb_wstrb_s0(wstrb_s[0]),
    .sb_bvalid_s0(bvalid_s[0]), .sb_bready_s0(bready_s[0]), .sb_bresp_s0(bresp_s[0]),
    .sb_arvalid_s1(arvalid_s[1]), .sb_arready_s1(arready_s[1]), .sb_araddr_s1(araddr_s[1]),
    .sb_rvalid_s1(rvalid_s[1]), .sb_rready_s1(rready_s[1]), .sb_rdata_s1(rdata_s[1]),
    .sb_wvalid_s1(wvalid_s[1]), .sb_wready_s1(wready_s[1]), .sb_waddr_s1(waddr_s[1]),
    .sb_wdata_s1(wdata_s[1]), .sb_wstrb_s1(wstrb_s[1]),
    .sb_bvalid_s1(bvalid_s[1]), .sb_bready_s1(bready_s[1]), .sb_bresp_s1(bresp_s[1])
  );

  // Idle row: out of reset, masters always ready for responses, nothing requested.
  function automatic vec_t blank();
    vec_t v;
    v = '{default: '0};
    v.rst_n      = 1'b1;
    v.rready     = 2'b11;
    v.bready     = 2'b11;
    v.e_rready_s = 2'b11;
    v.e_bready_s = 2'b11;
    return v;
  endfunction

  task automatic chk(input int row, input string name, input int idx,
                     input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL row %0d %s[%0d]: got %h expected %h", row, name, idx, act, exp);
    end
  endtask

  // Drive one cycle's inputs after the falling edge, compare the combinational
  // outputs before the next rising edge commits owner state.
  task automatic apply(input vec_t v);
    @(negedge clk);
    rst_n     = v.rst_n;
    arvalid_m = v.arvalid;  araddr_m = v.araddr;  rready_m = v.rready;
    wvalid_m  = v.wvalid;   waddr_m  = v.waddr;   wdata_m  = v.wdata;
    wstrb_m   = v.wstrb;    bready_m = v.bready;
    arready_s = v.arready_s; rvalid_s = v.rvalid_s; rdata_s = v.rdata_s;
    wready_s  = v.wready_s;  bvalid_s = v.bvalid_s; bresp_s = v.bresp_s;
    #2;
    for (int i = 0; i < 2; i++) begin
      chk(n_vec, "arready_m", i, 32'(arready_m[i]), 32'(v.e_arready[i]));
      chk(n_vec, "rvalid_m",  i, 32'(rvalid_m[i]),  32'(v.e_rvalid[i]));
      chk(n_vec, "rdata_m",   i, rdata_m[i],        v.e_rdata[i]);
      chk(n_vec, "wready_m",  i, 32'(wready_m[i]),  32'(v.e_wready[i]));
      chk(n_vec, "bvalid_m",  i, 32'(bvalid_m[i]),  32'(v.e_bvalid[i]));
      chk(n_vec, "bresp_m",   i, 32'(bresp_m[i]),   32'(v.e_bresp[i]));
      chk(n_vec, "arvalid_s", i, 32'(arvalid_s[i]), 32'(v.e_arvalid_s[i]));
      chk(n_vec, "rready_s",  i, 32'(rready_s[i]),  32'(v.e_rready_s[i]));
      chk(n_vec, "wvalid_s",  i, 32'(wvalid_s[i]),  32'(v.e_wvalid_s[i]));
      chk(n_vec, "bready_s",  i, 32'(bready_s[i]),  32'(v.e_bready_s[i]));
      if (v.e_arvalid_s[i] || v.arvalid == 2'b00)
        chk(n_vec, "araddr_s", i, araddr_s[i], v.e_araddr_s[i]);
      if (v.e_wvalid_s[i] || v.wvalid == 2'b00) begin
        chk(n_vec, "waddr_s", i, waddr_s[i], v.e_waddr_s[i]);
        chk(n_vec, "wdata_s", i, wdata_s[i], v.e_wdata_s[i]);
        chk(n_vec, "wstrb_s", i, 32'(wstrb_s[i]), 32'(v.e_wstrb_s[i]));
      end
    end
    n_vec++;
  endtask

  vec_t tbl[$];
  vec_t v;

  initial begin
    rst_n = 1'b0;
    arvalid_m = '0; araddr_m = '0; rready_m = '1; wvalid_m = '0; waddr_m = '0;
    wdata_m = '0; wstrb_m = '0; bready_m = '1;
    arready_s = '0; rvalid_s = '0; rdata_s = '0; wready_s = '0; bvalid_s = '0; bresp_s = '0;

    // reset state
    v = blank(); v.rst_n = 1'b0; tbl.push_back(v);
    v = blank(); tbl.push_back(v);

    // single m0 read to slave 0, data two cycles later; m0 briefly not ready
    v = blank(); v.arvalid = 2'b01; v.araddr[0] = 32'h0000_0100; v.arready_s = 2'b01;
    v.e_arready = 2'b01; v.e_arvalid_s = 2'b01; v.e_araddr_s[0] = 32'h0000_0100; tbl.push_back(v);
    v = blank(); v.rready = 2'b10; v.e_rready_s = 2'b10; tbl.push_back(v);
    v = blank(); v.rvalid_s = 2'b01; v.rdata_s[0] = 32'hDEAD_BEEF;
    v.e_rvalid = 2'b01; v.e_rdata[0] = 32'hDEAD_BEEF; tbl.push_back(v);
    v = blank(); tbl.push_back(v);

    // both masters read slave 0: m1 wins, m0 waits, m0 issues as m1's data returns
    v = blank(); v.arvalid = 2'b11; v.araddr[0] = 32'h40; v.araddr[1] = 32'h40; v.arready_s = 2'b01;
    v.e_arready = 2'b10; v.e_arvalid_s = 2'b01; v.e_araddr_s[0] = 32'h40; tbl.push_back(v);
    v = blank(); v.arvalid = 2'b01; v.araddr[0] = 32'h40; v.arready_s = 2'b01; tbl.push_back(v);
    v = blank(); v.arvalid = 2'b01; v.araddr[0] = 32'h40; v.arready_s = 2'b01;
    v.rvalid_s = 2'b01; v.rdata_s[0] = 32'h1111_2222;
    v.e_rvalid = 2'b10; v.e_rdata[1] = 32'h1111_2222;
    v.e_arready = 2'b01; v.e_arvalid_s = 2'b01; v.e_araddr_s[0] = 32'h40; tbl.push_back(v);
    v = blank(); v.rvalid_s = 2'b01; v.rdata_s[0] = 32'h3333_4444;
    v.e_rvalid = 2'b01; v.e_rdata[0] = 32'h3333_4444; tbl.push_back(v);

    // m0 read slave 0 and m1 write slave 1 in the same cycle
    v = blank(); v.arvalid = 2'b01; v.araddr[0] = 32'h0; v.arready_s = 2'b01;
    v.wvalid = 2'b10; v.waddr[1] = 32'h1000_0004; v.wdata[1] = 32'h55; v.wstrb[1] = 4'h1;
    v.wready_s = 2'b10;
    v.e_arready = 2'b01; v.e_arvalid_s = 2'b01; v.e_araddr_s[0] = 32'h0;
    v.e_wready = 2'b10; v.e_wvalid_s = 2'b10; v.e_waddr_s[1] = 32'h1000_0004;
    v.e_wdata_s[1] = 32'h55; v.e_wstrb_s[1] = 4'h1; tbl.push_back(v);
    v = blank(); v.bvalid_s = 2'b10; v.rvalid_s = 2'b01; v.rdata_s[0] = 32'hA5A5_A5A5;
    v.e_bvalid = 2'b10; v.e_rvalid = 2'b01; v.e_rdata[0] = 32'hA5A5_A5A5; tbl.push_back(v);

    // slave 1 stalls arready for 3 cycles; then m1 holds off rready once
    for (int k = 0; k < 3; k++) begin
      v = blank(); v.arvalid = 2'b10; v.araddr[1] = 32'h1000_0008;
      v.e_arvalid_s = 2'b10; v.e_araddr_s[1] = 32'h1000_0008; tbl.push_back(v);
    end
    v = blank(); v.arvalid = 2'b10; v.araddr[1] = 32'h1000_0008; v.arready_s = 2'b10;
    v.e_arready = 2'b10; v.e_arvalid_s = 2'b10; v.e_araddr_s[1] = 32'h1000_0008; tbl.push_back(v);
    v = blank(); v.rvalid_s = 2'b10; v.rdata_s[1] = 32'hCAFE_F00D; v.rready = 2'b01;
    v.e_rvalid = 2'b10; v.e_rdata[1] = 32'hCAFE_F00D; v.e_rready_s = 2'b01; tbl.push_back(v);
    v = blank(); v.rvalid_s = 2'b10; v.rdata_s[1] = 32'hCAFE_F00D;
    v.e_rvalid = 2'b10; v.e_rdata[1] = 32'hCAFE_F00D; tbl.push_back(v);
    v = blank(); tbl.push_back(v);

    foreach (tbl[i]) apply(tbl[i]);

    // Hand-written: reset in the middle of an m1 read to slave 0, then a stale beat.
    v = blank(); v.arvalid = 2'b10; v.araddr[1] = 32'h200; v.arready_s = 2'b01;
    v.e_arready = 2'b10; v.e_arvalid_s = 2'b01; v.e_araddr_s[0] = 32'h200; apply(v);
    v = blank(); v.rst_n = 1'b0; v.rready = 2'b01; apply(v);
    v = blank(); v.rready = 2'b01; apply(v);
    v = blank(); v.rvalid_s = 2'b01; v.rdata_s[0] = 32'h1234_5678; v.rready = 2'b00; apply(v);
    v = blank(); v.arvalid = 2'b01; v.araddr[0] = 32'h300; v.arready_s = 2'b01;
    v.e_arready = 2'b01; v.e_arvalid_s = 2'b01; v.e_araddr_s[0] = 32'h300; apply(v);
    v = blank(); v.rvalid_s = 2'b01; v.rdata_s[0] = 32'h0BAD_F00D;
    v.e_rvalid = 2'b01; v.e_rdata[0] = 32'h0BAD_F00D; apply(v);

    // Hand-written: m1 back-to-back writes to slave 0, second issues with first bvalid.
    v = blank(); v.wvalid = 2'b10; v.waddr[1] = 32'h10; v.wdata[1] = 32'hAAAA_0001;
    v.wstrb[1] = 4'hF; v.wready_s = 2'b01;
    v.e_wready = 2'b10; v.e_wvalid_s = 2'b01; v.e_waddr_s[0] = 32'h10;
    v.e_wdata_s[0] = 32'hAAAA_0001; v.e_wstrb_s[0] = 4'hF; apply(v);
    v = blank(); v.wvalid = 2'b10; v.waddr[1] = 32'h10; v.wdata[1] = 32'hAAAA_0002;
    v.wstrb[1] = 4'hF; v.wready_s = 2'b01; v.bvalid_s = 2'b01; v.bresp_s = 2'b01;
    v.e_bvalid = 2'b10; v.e_bresp = 2'b10;
    v.e_wready = 2'b10; v.e_wvalid_s = 2'b01; v.e_waddr_s[0] = 32'h10;
    v.e_wdata_s[0] = 32'hAAAA_0002; v.e_wstrb_s[0] = 4'hF; apply(v);
    v = blank(); v.bvalid_s = 2'b01; v.bready = 2'b01;
    v.e_bvalid = 2'b10; v.e_bready_s = 2'b10; apply(v);
    v = blank(); v.bvalid_s = 2'b01; v.e_bvalid = 2'b10; apply(v);
    v = blank(); v.bvalid_s = 2'b01; v.bresp_s = 2'b01; apply(v);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, miscompares);
    $finish;
  end

endmodule
